// File: rtl/vga_if.sv
// Raster timing bundle handed from the timing generator to the sprite/colour stage.
interface vga_if;
  logic       pix_en;
  logic [9:0] hCount;
  logic [9:0] vCount;
  logic       bright;
  logic       hSync;
  logic       vSync;
  logic       frame_tick;
  logic [7:0] frame_count;

  modport master (
    output pix_en, hCount, vCount, bright, hSync, vSync, frame_tick, frame_count
  );

  modport slave (
    input pix_en, hCount, vCount, bright, hSync, vSync, frame_tick, frame_count
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-enable divider feeding nested h/v counters, plus
// zero-latency sync/bright decodes and a per-frame strobe with frame counter.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned H_TOTAL   = 800,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP_END  = 144,
  parameter int unsigned H_ACT_END = 784,
  parameter int unsigned V_TOTAL   = 525,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP_END  = 35,
  parameter int unsigned V_ACT_END = 515
) (
  input  logic  clk,
  input  logic  rst,
  vga_if.master vga
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned CNT_W = 10;
  localparam int unsigned FC_W  = 8;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);

  logic [DIV_W-1:0] div;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic [FC_W-1:0]  f_cnt;
  logic             pix_en_c;
  logic             frame_tick_c;

  assign pix_en_c     = (div == DIV_LAST);
  assign frame_tick_c = pix_en_c && (h_cnt == H_LAST) && (v_cnt == V_LAST);

  // Three nested counters; everything else is decoded from them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div   <= '0;
      h_cnt <= '0;
      v_cnt <= '0;
      f_cnt <= '0;
    end else begin
      div <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
      if (pix_en_c) begin
        if (h_cnt == H_LAST) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
        end else begin
          h_cnt <= h_cnt + CNT_W'(1);
        end
      end
      if (frame_tick_c) begin
        f_cnt <= f_cnt + FC_W'(1);
      end
    end
  end

  // Decodes track the counters in the same clk so downstream sees no skew.
  assign vga.pix_en      = pix_en_c;
  assign vga.hCount      = h_cnt;
  assign vga.vCount      = v_cnt;
  assign vga.hSync       = (h_cnt >= CNT_W'(H_SYNC));
  assign vga.vSync       = (v_cnt >= CNT_W'(V_SYNC));
  assign vga.bright      = (h_cnt >= CNT_W'(H_BP_END)) && (h_cnt < CNT_W'(H_ACT_END)) &&
                           (v_cnt >= CNT_W'(V_BP_END)) && (v_cnt < CNT_W'(V_ACT_END));
  assign vga.frame_tick  = frame_tick_c;
  assign vga.frame_count = f_cnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a shrunken raster (8x6 pixels, 192 clks per frame)
// so that full frames and the 256-frame counter wrap stay short.
module tb_vga_timing_gen;

  localparam int unsigned CD  = 4;
  localparam int unsigned HT  = 8;
  localparam int unsigned HS  = 2;
  localparam int unsigned HB  = 3;
  localparam int unsigned HA  = 7;
  localparam int unsigned VT  = 6;
  localparam int unsigned VS  = 1;
  localparam int unsigned VB  = 2;
  localparam int unsigned VA  = 5;
  localparam int unsigned FRM = CD * HT * VT;

  logic clk;
  logic rst;
  logic run;
  logic chk_en;

  int unsigned n;
  int unsigned cyc;
  int unsigned rst_gen;
  int          checks;
  int          errors;

  vga_if vif ();

  vga_timing_gen #(
    .CLK_DIV(CD), .H_TOTAL(HT), .H_SYNC(HS), .H_BP_END(HB), .H_ACT_END(HA),
    .V_TOTAL(VT), .V_SYNC(VS), .V_BP_END(VB), .V_ACT_END(VA)
  ) dut (
    .clk(clk),
    .rst(rst),
    .vga(vif.master)
  );

  initial begin
    clk = 1'b0;
    forever begin
      #5;
      if (run) clk = ~clk;
    end
  end

  // Edges elapsed since reset was last released; the reference model indexes on it.
  always @(posedge clk or posedge rst) begin
    if (rst) n <= 0;
    else     n <= n + 1;
  end

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge rst) rst_gen <= rst_gen + 1;

  function automatic logic [32:0] pk(input logic pix, input int unsigned h, input int unsigned v,
                                     input logic b, input logic hs, input logic vs,
                                     input logic tk, input int unsigned fc);
    logic [9:0] h10;
    logic [9:0] v10;
    logic [7:0] f8;
    h10 = 10'(h);
    v10 = 10'(v);
    f8  = 8'(fc);
    return {pix, h10, v10, b, hs, vs, tk, f8};
  endfunction

  // Reference: raster position is plain division of elapsed edges.
  function automatic logic [32:0] model(input int unsigned edges);
    int unsigned p, h, v, fc;
    logic pix, b, hs, vs, tk;
    p   = edges / CD;
    pix = ((edges % CD) == CD - 1);
    h   = p % HT;
    v   = (p / HT) % VT;
    fc  = (p / (HT * VT)) % 256;
    b   = (h >= HB) && (h < HA) && (v >= VB) && (v < VA);
    hs  = (h >= HS);
    vs  = (v >= VS);
    tk  = pix && (h == HT - 1) && (v == VT - 1);
    return pk(pix, h, v, b, hs, vs, tk, fc);
  endfunction

  function automatic logic [32:0] obs();
    return {vif.pix_en, vif.hCount, vif.vCount, vif.bright, vif.hSync, vif.vSync,
            vif.frame_tick, vif.frame_count};
  endfunction

  task automatic check(input string name, input logic [32:0] got, input logic [32:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s n=%0d got=%h exp=%h", name, n, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) check("model", obs(), model(n));
  end

  int unsigned last_tick_cyc;
  int unsigned last_tick_gen;
  logic        have_tick;

  // Frame strobes with no reset in between must be exactly one frame apart.
  always @(negedge clk) begin
    if (vif.frame_tick) begin
      if (have_tick && last_tick_gen == rst_gen)
        check_int("tick_spacing", int'(cyc - last_tick_cyc), int'(FRM));
      last_tick_cyc = cyc;
      last_tick_gen = rst_gen;
      have_tick     = 1'b1;
    end
  end

  task automatic wait_n(input int unsigned target, input string tag);
    int k;
    k = 0;
    while (n < target && k < 100000) begin
      @(negedge clk);
      k++;
    end
    check_int(tag, int'(n), int'(target));
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #($urandom_range(1, 3));
    rst = 1'b1;
    @(negedge clk);
    #2;
    rst = 1'b0;
  endtask

  typedef struct {
    int unsigned n;
    logic [32:0] exp;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int cnt_b, cnt_vs, cnt_hs, t0, k;
    logic got_tick;
    checks = 0;
    errors = 0;
    n = 0;
    cyc = 0;
    rst_gen = 0;
    have_tick = 1'b0;
    last_tick_cyc = 0;
    last_tick_gen = 0;
    chk_en = 1'b0;
    run = 1'b1;
    rst = 1'b1;

    vecs[0]  = '{0,   pk(0, 0, 0, 0, 0, 0, 0, 0)};
    vecs[1]  = '{3,   pk(1, 0, 0, 0, 0, 0, 0, 0)};
    vecs[2]  = '{4,   pk(0, 1, 0, 0, 0, 0, 0, 0)};
    vecs[3]  = '{8,   pk(0, 2, 0, 0, 1, 0, 0, 0)};
    vecs[4]  = '{32,  pk(0, 0, 1, 0, 0, 1, 0, 0)};
    vecs[5]  = '{44,  pk(0, 3, 1, 0, 1, 1, 0, 0)};
    vecs[6]  = '{76,  pk(0, 3, 2, 1, 1, 1, 0, 0)};
    vecs[7]  = '{88,  pk(0, 6, 2, 1, 1, 1, 0, 0)};
    vecs[8]  = '{92,  pk(0, 7, 2, 0, 1, 1, 0, 0)};
    vecs[9]  = '{104, pk(0, 2, 3, 0, 1, 1, 0, 0)};
    vecs[10] = '{164, pk(0, 1, 5, 0, 0, 1, 0, 0)};
    vecs[11] = '{191, pk(1, 7, 5, 0, 1, 1, 1, 0)};
    vecs[12] = '{192, pk(0, 0, 0, 0, 0, 0, 0, 1)};

    repeat (3) @(negedge clk);
    check("reset_state", obs(), 33'd0);
    chk_en = 1'b1;
    #1 rst = 1'b0;

    // Hand-computed raster points from reset release.
    for (int i = 0; i < 13; i++) begin
      wait_n(vecs[i].n, "vec_wait");
      check($sformatf("vec%0d", i), obs(), vecs[i].exp);
    end

    // Asynchronous reset with the clock parked low, mid-frame.
    wait_n(FRM + 108, "park_wait");
    run = 1'b0;
    chk_en = 1'b0;
    #20;
    check("parked_pre", obs(), model(FRM + 108));
    rst = 1'b1;
    #1;
    check("async_reset", obs(), 33'd0);
    #20;
    rst = 1'b0;
    #3;
    run = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check_int("pix_pattern", int'(vif.pix_en), (i % 4 == 3) ? 1 : 0);
      if (i == 4) check_int("h_after_4", int'(vif.hCount), 1);
      @(negedge clk);
    end
    chk_en = 1'b1;

    // Line period from successive hSync rising edges.
    t0 = 0;
    for (int e = 0; e < 2; e++) begin
      k = 0;
      while (vif.hSync !== 1'b0 && k < 100) begin @(negedge clk); k++; end
      while (vif.hSync !== 1'b1 && k < 200) begin @(negedge clk); k++; end
      if (e == 0) t0 = int'(cyc);
      else check_int("line_period", int'(cyc) - t0, int'(CD * HT));
    end

    // Whole-frame pixel tallies.
    wait_n(2 * FRM, "frame_align");
    cnt_b = 0; cnt_vs = 0; cnt_hs = 0;
    for (int i = 0; i < int'(FRM); i++) begin
      if (vif.pix_en) begin
        cnt_b  += int'(vif.bright);
        cnt_vs += int'(!vif.vSync);
        cnt_hs += int'(!vif.hSync);
      end
      @(negedge clk);
    end
    check_int("bright_pixels", cnt_b, int'((HA - HB) * (VA - VB)));
    check_int("vsync_low_pixels", cnt_vs, int'(VS * HT));
    check_int("hsync_low_pixels", cnt_hs, int'(HS * VT));

    // frame_count wrap after 256 frames.
    wait_n(256 * FRM - 1, "wrap_wait");
    check("pre_wrap", obs(), pk(1, HT - 1, VT - 1, 0, 1, 1, 1, 255));
    @(negedge clk);
    check("post_wrap", obs(), pk(0, 0, 0, 0, 0, 0, 0, 0));

    // Random one-clk reset pulses at arbitrary raster points.
    for (int r = 0; r < 6; r++) begin
      repeat ($urandom_range(20, 400)) @(negedge clk);
      pulse_reset();
    end

    // Next frame strobe lands one frame after release minus the startup offset.
    got_tick = 1'b0;
    k = 0;
    while (!got_tick && k < int'(2 * FRM)) begin
      @(negedge clk);
      k++;
      if (vif.frame_tick) got_tick = 1'b1;
    end
    check_int("tick_after_reset", got_tick ? int'(n) : -1, int'(FRM - 1));
    @(negedge clk);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
